// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared constants, colour type and sequencer states for the pixel path
package pixel_pkg;

    localparam int PIX_DATA_WIDTH    = 32;
    localparam int PIX_RBG_SIZE      = 24;
    localparam int PIX_SCREEN_WIDTH  = 640;
    localparam int PIX_SCREEN_HEIGHT = 480;
    localparam int PIX_TIMEOUT       = 1023;

    typedef logic [PIX_RBG_SIZE-1:0] colour_t;

    localparam colour_t PIX_FILL_COLOUR = 24'hFF00FF;

    typedef enum logic [1:0] {IDLE, SEEK, EMIT, DONE} comb_state_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_combinator_if.sv
// rtl/pixel_combinator_if.sv - queue broadcast/grant signals and the output pixel stream
interface pixel_combinator_if #(
    parameter int NUM_QUEUES = 4,
    parameter int DATA_WIDTH = 32,
    parameter int RBG_SIZE   = 24
);
    logic [DATA_WIDTH-1:0]          xpixel_check;
    logic [DATA_WIDTH-1:0]          ypixel_check;
    logic [NUM_QUEUES-1:0]          hit_i;
    logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i;
    logic [NUM_QUEUES-1:0]          pop_o;
    logic [RBG_SIZE-1:0]            out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic                           out_sop;
    logic                           out_eop;

    modport master (
        output xpixel_check, ypixel_check, pop_o,
        output out_data, out_valid, out_sop, out_eop,
        input  hit_i, colour_i, out_ready
    );

    modport slave (
        input  xpixel_check, ypixel_check, pop_o,
        input  out_data, out_valid, out_sop, out_eop,
        output hit_i, colour_i, out_ready
    );
endinterface

// File: rtl/pixel_combinator_raster_counter.sv
// rtl/pixel_combinator_raster_counter.sv - raster-order x/y position with first/last flags
module raster_counter
    import pixel_pkg::*;
#(
    parameter int WIDTH  = PIX_SCREEN_WIDTH,
    parameter int HEIGHT = PIX_SCREEN_HEIGHT,
    localparam int XW    = cnt_width(WIDTH),
    localparam int YW    = cnt_width(HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_step,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_first,
    output logic          o_last
);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_step) begin
            if (r_x == XW'(WIDTH - 1)) begin
                r_x <= '0;
                r_y <= (r_y == YW'(HEIGHT - 1)) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_first = (r_x == '0) && (r_y == '0);
    assign o_last  = (r_x == XW'(WIDTH - 1)) && (r_y == YW'(HEIGHT - 1));

endmodule

// File: rtl/pixel_combinator.sv
// rtl/pixel_combinator.sv - raster sequencer granting matching queue heads onto the pixel stream
module pixel_combinator
    import pixel_pkg::*;
#(
    parameter int NUM_QUEUES    = 4,
    parameter int DATA_WIDTH    = PIX_DATA_WIDTH,
    parameter int RBG_SIZE      = PIX_RBG_SIZE,
    parameter int SCREEN_WIDTH  = PIX_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = PIX_SCREEN_HEIGHT,
    parameter int TIMEOUT       = PIX_TIMEOUT,
    parameter logic [RBG_SIZE-1:0] FILL_COLOUR = RBG_SIZE'(PIX_FILL_COLOUR)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    pixel_combinator_if.master  bus,
    output logic                busy,
    output logic                frame_done,
    output logic                err_multi,
    output logic                err_timeout
);

    localparam int XW = cnt_width(SCREEN_WIDTH);
    localparam int YW = cnt_width(SCREEN_HEIGHT);
    localparam int CW = cnt_width(TIMEOUT + 1);

    comb_state_t           r_state, w_state_n;
    logic [NUM_QUEUES-1:0] r_pop, w_pop_n, w_grant;
    logic [RBG_SIZE-1:0]   r_data, w_data_n, w_grant_colour;
    logic [CW-1:0]         r_cnt, w_cnt_n;
    logic                  r_err_multi, w_err_multi_n;
    logic                  r_err_timeout, w_err_timeout_n;
    logic                  w_step, w_clear, w_first, w_last;
    logic [XW-1:0]         w_x;
    logic [YW-1:0]         w_y;

    raster_counter #(
        .WIDTH  (SCREEN_WIDTH),
        .HEIGHT (SCREEN_HEIGHT)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_step  (w_step),
        .o_x     (w_x),
        .o_y     (w_y),
        .o_first (w_first),
        .o_last  (w_last)
    );

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        w_grant        = '0;
        w_grant_colour = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (bus.hit_i[i]) begin
                w_grant        = '0;
                w_grant[i]     = 1'b1;
                w_grant_colour = bus.colour_i[i*RBG_SIZE +: RBG_SIZE];
            end
        end
    end

    always_comb begin
        w_state_n       = r_state;
        w_pop_n         = '0;
        w_data_n        = r_data;
        w_cnt_n         = r_cnt;
        w_err_multi_n   = 1'b0;
        w_err_timeout_n = 1'b0;
        w_step          = 1'b0;
        w_clear         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_n = SEEK;
                    w_clear   = 1'b1;
                    w_cnt_n   = '0;
                end
            end
            SEEK: begin
                if (|bus.hit_i) begin
                    w_state_n     = EMIT;
                    w_pop_n       = w_grant;
                    w_data_n      = w_grant_colour;
                    w_err_multi_n = ($countones(bus.hit_i) > 1);
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    // The TIMEOUT-th empty cycle substitutes the fill pixel.
                    w_state_n       = EMIT;
                    w_data_n        = FILL_COLOUR;
                    w_err_timeout_n = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    w_cnt_n = '0;
                    if (w_last) begin
                        w_state_n = DONE;
                    end else begin
                        w_state_n = SEEK;
                        w_step    = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pop         <= '0;
            r_data        <= '0;
            r_cnt         <= '0;
            r_err_multi   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_pop         <= w_pop_n;
            r_data        <= w_data_n;
            r_cnt         <= w_cnt_n;
            r_err_multi   <= w_err_multi_n;
            r_err_timeout <= w_err_timeout_n;
        end
    end

    assign bus.xpixel_check = DATA_WIDTH'(w_x);
    assign bus.ypixel_check = DATA_WIDTH'(w_y);
    assign bus.pop_o        = r_pop;
    assign bus.out_data     = r_data;
    assign bus.out_valid    = (r_state == EMIT);
    assign bus.out_sop      = (r_state == EMIT) && w_first;
    assign bus.out_eop      = (r_state == EMIT) && w_last;
    assign busy             = (r_state == SEEK) || (r_state == EMIT);
    assign frame_done       = (r_state == DONE);
    assign err_multi        = r_err_multi;
    assign err_timeout      = r_err_timeout;

endmodule

// File: tb/tb_pixel_combinator.sv
// tb/tb_pixel_combinator.sv - directed table-driven bench for pixel_combinator on a 4x2 screen
module tb_pixel_combinator;
    import pixel_pkg::*;

    localparam int NQ = 4;
    localparam int DW = 32;
    localparam int RB = 24;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int TO = 8;
    localparam logic [RB-1:0] FILL  = 24'hFF00FF;
    localparam logic [RB-1:0] COL_A = 24'hAAAAAA;
    localparam logic [RB-1:0] COL_B = 24'hBBBBBB;

    typedef struct {
        int            delay;
        bit            start_pulse;
        int            exp_x;
        int            exp_y;
        logic [RB-1:0] exp_data;
        logic [NQ-1:0] exp_pop;
        bit            exp_sop;
        bit            exp_eop;
        int            exp_wait;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, frame_done, err_multi, err_timeout;
    int   mode = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pop0 = 0, n_pop2 = 0, n_multi = 0, n_tout = 0, n_done = 0;

    pixel_combinator_if #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW), .RBG_SIZE(RB)) bus ();

    pixel_combinator #(
        .NUM_QUEUES    (NQ),
        .DATA_WIDTH    (DW),
        .RBG_SIZE      (RB),
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .TIMEOUT       (TO),
        .FILL_COLOUR   (FILL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bus         (bus.master),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_multi   (err_multi),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Queue model: mode 0 q0 always hits, mode 1 double hit at origin, mode 2 hole at (1,0).
    always_comb begin
        logic [RB-1:0] c;
        c = RB'(bus.xpixel_check + 16 * bus.ypixel_check);
        bus.hit_i    = 4'b0001;
        bus.colour_i = '0;
        bus.colour_i[RB-1:0] = c;
        if (mode == 1 && bus.xpixel_check == 0 && bus.ypixel_check == 0) begin
            bus.hit_i = 4'b0110;
            bus.colour_i[1*RB +: RB] = COL_A;
            bus.colour_i[2*RB +: RB] = COL_B;
        end else if (mode == 2 && bus.xpixel_check == 1 && bus.ypixel_check == 0) begin
            bus.hit_i = 4'b0000;
        end
    end

    always @(posedge clk) begin
        if (bus.pop_o[0]) n_pop0++;
        if (bus.pop_o[2]) n_pop2++;
        if (err_multi)    n_multi++;
        if (err_timeout)  n_tout++;
        if (frame_done)   n_done++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t tab[24];

    initial begin
        int wt;
        int s_pop0, s_pop2, s_multi, s_tout, s_done;
        vec_t v;

        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8; k++) begin
                v.delay       = 0;
                v.start_pulse = 1'b0;
                v.exp_x       = k % W;
                v.exp_y       = k / W;
                v.exp_data    = RB'((k % W) + 16 * (k / W));
                v.exp_pop     = 4'b0001;
                v.exp_sop     = (k == 0);
                v.exp_eop     = (k == 7);
                v.exp_wait    = 1;
                tab[f*8+k]    = v;
            end
        end
        tab[2].delay        = 5;
        tab[2].start_pulse  = 1'b1;
        tab[8].exp_data     = COL_A;
        tab[8].exp_pop      = 4'b0010;
        tab[17].exp_data    = FILL;
        tab[17].exp_pop     = 4'b0000;
        tab[17].exp_wait    = TO;

        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pop", 32'(bus.pop_o), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_x", bus.xpixel_check, 0);
        chk("rst_y", bus.ypixel_check, 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_err", 32'({err_multi, err_timeout}), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("start_in_reset_busy", 32'(busy), 0);

        for (int f = 0; f < 3; f++) begin
            mode   = f;
            s_pop0 = n_pop0; s_pop2 = n_pop2; s_multi = n_multi; s_tout = n_tout; s_done = n_done;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            bus.out_ready = 1'b1;
            for (int k = 0; k < 8; k++) begin
                v  = tab[f*8+k];
                wt = 0;
                while (!bus.out_valid && wt < 40) begin
                    @(negedge clk);
                    wt++;
                end
                chk($sformatf("f%0d_p%0d_wait", f, k), 32'(wt), 32'(v.exp_wait));
                chk($sformatf("f%0d_p%0d_data", f, k), 32'(bus.out_data), 32'(v.exp_data));
                chk($sformatf("f%0d_p%0d_sop", f, k), 32'(bus.out_sop), 32'(v.exp_sop));
                chk($sformatf("f%0d_p%0d_eop", f, k), 32'(bus.out_eop), 32'(v.exp_eop));
                chk($sformatf("f%0d_p%0d_x", f, k), bus.xpixel_check, 32'(v.exp_x));
                chk($sformatf("f%0d_p%0d_y", f, k), bus.ypixel_check, 32'(v.exp_y));
                chk($sformatf("f%0d_p%0d_pop", f, k), 32'(bus.pop_o), 32'(v.exp_pop));
                if (v.delay > 0) begin
                    bus.out_ready = 1'b0;
                    for (int d = 0; d < v.delay; d++) begin
                        if (v.start_pulse && d == 1) start = 1'b1;
                        @(negedge clk);
                        start = 1'b0;
                        chk($sformatf("stall%0d_valid", d), 32'(bus.out_valid), 1);
                        chk($sformatf("stall%0d_data", d), 32'(bus.out_data), 32'(v.exp_data));
                        chk($sformatf("stall%0d_x", d), bus.xpixel_check, 32'(v.exp_x));
                        chk($sformatf("stall%0d_pop", d), 32'(bus.pop_o), 0);
                    end
                    bus.out_ready = 1'b1;
                end
                @(negedge clk);
            end
            chk($sformatf("f%0d_done_pulse", f), 32'(frame_done), 1);
            chk($sformatf("f%0d_done_busy", f), 32'(busy), 0);
            @(negedge clk);
            chk($sformatf("f%0d_done_clear", f), 32'(frame_done), 0);
            bus.out_ready = 1'b0;
            repeat (2) @(negedge clk);
            chk($sformatf("f%0d_idle_busy", f), 32'(busy), 0);
            chk($sformatf("f%0d_n_done", f), 32'(n_done - s_done), 1);
            chk($sformatf("f%0d_n_pop0", f), 32'(n_pop0 - s_pop0), (f == 0) ? 8 : 7);
            chk($sformatf("f%0d_n_pop2", f), 32'(n_pop2 - s_pop2), 0);
            chk($sformatf("f%0d_n_multi", f), 32'(n_multi - s_multi), (f == 1) ? 1 : 0);
            chk($sformatf("f%0d_n_tout", f), 32'(n_tout - s_tout), (f == 2) ? 1 : 0);
        end

        // Reset while presenting (1,1): frame abandoned, no frame_done.
        mode   = 0;
        s_done = n_done;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wt = 0;
            while (!bus.out_valid && wt < 40) begin
                @(negedge clk);
                wt++;
            end
            if (k < 5) @(negedge clk);
        end
        chk("rmid_x", bus.xpixel_check, 1);
        chk("rmid_y", bus.ypixel_check, 1);
        bus.out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rmid_valid", 32'(bus.out_valid), 0);
        chk("rmid_busy", 32'(busy), 0);
        chk("rmid_data", 32'(bus.out_data), 0);
        chk("rmid_coord", bus.xpixel_check | bus.ypixel_check, 0);
        chk("rmid_flags", 32'({frame_done, err_multi, err_timeout, bus.out_sop, bus.out_eop}), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rmid_no_done", 32'(n_done - s_done), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wt = 0;
        while (!bus.out_valid && wt < 40) begin
            @(negedge clk);
            wt++;
        end
        chk("restart_wait", 32'(wt), 1);
        chk("restart_coord", bus.xpixel_check | bus.ypixel_check, 0);
        chk("restart_sop", 32'(bus.out_sop), 1);
        chk("restart_data", 32'(bus.out_data), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
